note_judge: RTL and testbench
=============================

# note_judge

Rhythm-game hit judge: turns debounced drum inputs and chart note-arrival events into the single-cycle `increase_score` / `decrease_score` pulses consumed by `score_counter` and `combo_counter`. Sits between the chart/note scroller and the scoring counters. Opens a timing window per note, grades hits as great, good or miss, and reports the last grade for the display.

## Interface
- `WINDOW_CYCLES`, 24: length of the judgement window in clock cycles (≥ 2).
- `GREAT_START`, 8: first window count graded great.
- `GREAT_END`, 16: first window count after the great region; requires `GREAT_START < GREAT_END ≤ WINDOW_CYCLES`.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `note_arrive`  in  1  one-cycle pulse: a note has reached the judgement line.
- `note_is_ka`  in  1  note type, sampled with `note_arrive` (0 = don, 1 = ka).
- `hit_don`  in  1  don drum level, high while pressed.
- `hit_ka`  in  1  ka drum level, high while pressed.
- `increase_score`  out  1  one-cycle pulse for a correct hit (great or good).
- `decrease_score`  out  1  one-cycle pulse for a miss or wrong drum.
- `last_result`  out  2  grade of the last judged note: 00 none, 01 great, 10 good, 11 miss.
- `window_open`  out  1  high while a note awaits judgement.

## Operation
- Edge detect: registers `prev_don` and `prev_ka`. A hit is a rising edge: input high and prev low. Only the press is judged, never the held level.
- States:
  - IDLE: no note pending.
  - OPEN: note pending; holds the latched type and window counter `cnt`. `cnt` width is `$clog2(WINDOW_CYCLES)`.
- IDLE behaviour:
  - `note_arrive` → OPEN, `cnt` ← 0, latch `note_is_ka`.
  - Hits in IDLE, including a hit in the same cycle as `note_arrive`, are stray. They are ignored and produce no pulse.
- OPEN behaviour (evaluated in priority order each cycle; `c` is the current `cnt`):
  1. Exactly one rising edge and it matches the latched type → judge correct. Grade great if `GREAT_START ≤ c < GREAT_END`, else good. Then `increase_score`.
  2. Wrong drum edge, or don and ka edges in the same cycle → judge miss. Then `decrease_score`.
  3. No edge, and `note_arrive` asserted → old note judged miss (`decrease_score`). The new note is latched with `cnt` ← 0 and the state stays OPEN.
  4. No edge, and `c == WINDOW_CYCLES-1` → miss (expiry). Then `decrease_score`, go to IDLE.
  5. Otherwise `cnt` ← `cnt` + 1.
- After a case-1 or case-2 judgement: go to IDLE, unless `note_arrive` is also asserted that cycle. In that case the new note opens with `cnt` ← 0.
- One judgement per note. `increase_score` and `decrease_score` are never high in the same cycle.
- `last_result` updates only on a judgement and holds between notes.

## Timing
- All inputs are sampled on the rising edge of `clk`. Outputs are registered.
- Latency: an edge or event sampled at edge N produces its pulse in the cycle after edge N. The pulse is exactly one cycle wide.
- `window_open` is high from the cycle after the `note_arrive` sample until the cycle after the judgement.
- For a note sampled at edge N, `cnt` = k at edge N+1+k. Expiry is judged at edge N+WINDOW_CYCLES.
- Reset (any cycle, including mid-window):
  - State goes to IDLE, `cnt` = 0.
  - `increase_score`, `decrease_score` and `window_open` = 0; `last_result` = 00.
  - `prev_don` and `prev_ka` load 1, so a drum held through reset yields no hit until released and pressed again.
  - A pending note is discarded without a pulse.
- Back-to-back `note_arrive` on consecutive cycles is legal. Each preceding note is judged miss.

## Test plan
- Don note at edge 0; don press sampled at edge 11 (c=10) → `increase_score` pulse in the cycle after edge 11; `last_result`=01; `window_open` drops.
- Ka note; ka press sampled at c=3 → `increase_score` pulse; `last_result`=10 (good).
- Don note; ka press at c=5 → one `decrease_score` pulse; `last_result`=11. A later don press in the same window is ignored (already IDLE).
- Don note, no press → `decrease_score` exactly once, judged at edge 24 after the arrival sample; `last_result`=11.
- Second `note_arrive` at c=4 of a pending note → one `decrease_score`; new window restarts; a correct press 10 cycles later → `increase_score`, grade great.
- Stray and held cases:
  - Don held high across reset, then a note opens → no pulse.
  - Release, re-press at c=9 → `increase_score`.
  - A press in IDLE → no pulses.
  - Don and ka pressed together in a window → `decrease_score`.

Source files
------------

// File: rtl/note_judge_if.sv
// Judge-side bundle: note events and drum levels in, score pulses and grade status out.
interface note_judge_if;
  logic       note_arrive;
  logic       note_is_ka;
  logic       hit_don;
  logic       hit_ka;
  logic       increase_score;
  logic       decrease_score;
  logic [1:0] last_result;
  logic       window_open;

  modport master (
    output note_arrive, note_is_ka, hit_don, hit_ka,
    input  increase_score, decrease_score, last_result, window_open
  );

  modport slave (
    input  note_arrive, note_is_ka, hit_don, hit_ka,
    output increase_score, decrease_score, last_result, window_open
  );
endinterface

// File: rtl/note_judge.sv
// Rhythm-game hit judge: grades drum presses against a per-note timing window and
// emits single-cycle score pulses plus the last grade.
module note_judge #(
  parameter int unsigned WINDOW_CYCLES = 24,
  parameter int unsigned GREAT_START   = 8,
  parameter int unsigned GREAT_END     = 16
) (
  input  logic         clk,
  input  logic         reset,
  note_judge_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WINDOW_CYCLES);

  localparam logic [1:0] ResNone  = 2'b00;
  localparam logic [1:0] ResGreat = 2'b01;
  localparam logic [1:0] ResGood  = 2'b10;
  localparam logic [1:0] ResMiss  = 2'b11;

  typedef enum logic [0:0] {StIdle, StOpen} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            note_ka_q;
  logic            prev_don_q;
  logic            prev_ka_q;
  logic            inc_q;
  logic            dec_q;
  logic [1:0]      last_q;

  logic don_edge;
  logic ka_edge;
  logic any_edge;
  logic correct;
  logic in_great;
  logic expired;

  always_comb begin
    don_edge = bus.hit_don & ~prev_don_q;
    ka_edge  = bus.hit_ka & ~prev_ka_q;
    any_edge = don_edge | ka_edge;
    // Exactly one edge, and it is the drum the latched note asks for.
    correct  = (don_edge ^ ka_edge) && (ka_edge == note_ka_q);
    in_great = (32'(cnt_q) >= GREAT_START) && (32'(cnt_q) < GREAT_END);
    expired  = (32'(cnt_q) == WINDOW_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      note_ka_q  <= 1'b0;
      // Loading 1 means a drum held through reset never counts as a press.
      prev_don_q <= 1'b1;
      prev_ka_q  <= 1'b1;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      last_q     <= ResNone;
    end else begin
      prev_don_q <= bus.hit_don;
      prev_ka_q  <= bus.hit_ka;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.note_arrive) begin
            state_q   <= StOpen;
            cnt_q     <= '0;
            note_ka_q <= bus.note_is_ka;
          end
        end
        StOpen: begin
          if (any_edge || bus.note_arrive || expired) begin
            if (correct) begin
              inc_q  <= 1'b1;
              last_q <= in_great ? ResGreat : ResGood;
            end else begin
              dec_q  <= 1'b1;
              last_q <= ResMiss;
            end
            // A new note arriving alongside any judgement reopens the window.
            if (bus.note_arrive) begin
              cnt_q     <= '0;
              note_ka_q <= bus.note_is_ka;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.increase_score = inc_q;
  assign bus.decrease_score = dec_q;
  assign bus.last_result    = last_q;
  assign bus.window_open    = (state_q == StOpen);

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: hand-computed pulses, grades and window status per step.
module tb_note_judge;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  note_judge_if bus ();

  note_judge #(
    .WINDOW_CYCLES (24),
    .GREAT_START   (8),
    .GREAT_END     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic inc, input logic dec,
                      input logic [1:0] last, input logic win);
    chk({tag, ".inc"}, 32'(bus.increase_score), 32'(inc));
    chk({tag, ".dec"}, 32'(bus.decrease_score), 32'(dec));
    chk({tag, ".last"}, 32'(bus.last_result), 32'(last));
    chk({tag, ".win"}, 32'(bus.window_open), 32'(win));
  endtask

  // n edges with no judgement expected; window and grade must hold steady.
  task automatic quiet(input string tag, input int n, input logic [1:0] last, input logic win);
    for (int i = 0; i < n; i++) begin
      tick();
      outs(tag, 1'b0, 1'b0, last, win);
    end
  endtask

  task automatic arrive(input logic ka);
    bus.note_arrive = 1'b1;
    bus.note_is_ka  = ka;
    tick();
    bus.note_arrive = 1'b0;
    bus.note_is_ka  = 1'b0;
  endtask

  initial begin
    bus.note_arrive = 1'b0;
    bus.note_is_ka  = 1'b0;
    bus.hit_don     = 1'b1;
    bus.hit_ka      = 1'b0;
    reset           = 1'b1;
    tick();
    tick();
    outs("reset", 1'b0, 1'b0, 2'b00, 1'b0);

    // Don held through reset: note opens, held level is not a hit.
    reset = 1'b0;
    arrive(1'b0);
    outs("held_open", 1'b0, 1'b0, 2'b00, 1'b1);
    quiet("held", 3, 2'b00, 1'b1);          // c=0..2
    bus.hit_don = 1'b0;
    quiet("release", 6, 2'b00, 1'b1);       // c=3..8
    bus.hit_don = 1'b1;
    tick();                                 // c=9 -> great
    outs("repress", 1'b1, 1'b0, 2'b01, 1'b0);
    bus.hit_don = 1'b0;
    tick();
    outs("repress_after", 1'b0, 1'b0, 2'b01, 1'b0);

    // Stray press in IDLE.
    bus.hit_don = 1'b1;
    tick();
    outs("stray", 1'b0, 1'b0, 2'b01, 1'b0);
    bus.hit_don = 1'b0;
    tick();

    // Don note at edge 0, press sampled at edge 11 (c=10) -> great.
    arrive(1'b0);
    quiet("don_wait", 10, 2'b01, 1'b1);
    bus.hit_don = 1'b1;
    tick();
    outs("don_great", 1'b1, 1'b0, 2'b01, 1'b0);
    bus.hit_don = 1'b0;
    tick();
    outs("don_great_after", 1'b0, 1'b0, 2'b01, 1'b0);

    // Ka note, ka press at c=3 -> good.
    arrive(1'b1);
    quiet("ka_wait", 3, 2'b01, 1'b1);
    bus.hit_ka = 1'b1;
    tick();
    outs("ka_good", 1'b1, 1'b0, 2'b10, 1'b0);
    bus.hit_ka = 1'b0;
    tick();
    outs("ka_good_after", 1'b0, 1'b0, 2'b10, 1'b0);

    // Don note, no press: miss at edge 24 after arrival.
    arrive(1'b0);
    quiet("expire_wait", 23, 2'b10, 1'b1);
    tick();
    outs("expire", 1'b0, 1'b1, 2'b11, 1'b0);
    tick();
    outs("expire_after", 1'b0, 1'b0, 2'b11, 1'b0);

    // Second arrival at c=4: old note missed, new window, press at c=9 -> great.
    arrive(1'b0);
    quiet("second_wait", 4, 2'b11, 1'b1);
    arrive(1'b0);
    outs("second_arrive", 1'b0, 1'b1, 2'b11, 1'b1);
    quiet("second_new", 9, 2'b11, 1'b1);
    bus.hit_don = 1'b1;
    tick();
    outs("second_great", 1'b1, 1'b0, 2'b01, 1'b0);
    bus.hit_don = 1'b0;
    tick();

    // Don note, ka press at c=5 -> miss; a later don press is ignored.
    arrive(1'b0);
    quiet("wrong_wait", 5, 2'b01, 1'b1);
    bus.hit_ka = 1'b1;
    tick();
    outs("wrong_drum", 1'b0, 1'b1, 2'b11, 1'b0);
    bus.hit_ka = 1'b0;
    quiet("wrong_after", 2, 2'b11, 1'b0);
    bus.hit_don = 1'b1;
    tick();
    outs("late_don", 1'b0, 1'b0, 2'b11, 1'b0);
    bus.hit_don = 1'b0;
    tick();

    // Ka note graded good first, then both drums together on a don note -> miss.
    arrive(1'b1);
    bus.hit_ka = 1'b1;
    tick();                                 // c=0 -> good
    outs("ka_c0", 1'b1, 1'b0, 2'b10, 1'b0);
    bus.hit_ka = 1'b0;
    tick();
    arrive(1'b0);
    quiet("both_wait", 2, 2'b10, 1'b1);
    bus.hit_don = 1'b1;
    bus.hit_ka  = 1'b1;
    tick();
    outs("both", 1'b0, 1'b1, 2'b11, 1'b0);
    bus.hit_don = 1'b0;
    bus.hit_ka  = 1'b0;
    tick();

    // Reset mid-window discards the note without a pulse.
    arrive(1'b0);
    quiet("mid_wait", 3, 2'b11, 1'b1);
    reset = 1'b1;
    tick();
    outs("mid_reset", 1'b0, 1'b0, 2'b00, 1'b0);
    reset = 1'b0;
    quiet("post_reset", 30, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
